carbon_irq_ctrl: RTL

// - Interrupt controller that drives the core-side irq_if request signals (irq_valid/vector/prio/pending).
// - Latches rising edges on N_SRC peripheral lines and applies a per-source enable mask.
// - Arbitrates pending sources and presents one vector to the CPU core (z80/z380 family), holding it until acknowledged.
// - Sits between the peripheral fabric and the core irq port; configured through a simple register write port.

---
 rtl/carbon_irq_ctrl.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/carbon_irq_ctrl.sv
//------------------------------------------------------------------------------
// Module  : carbon_irq_ctrl
// Brief   : Edge-latching, maskable interrupt controller presenting one vector
//           to the core until acknowledged. Optional per-source priority is
//           enabled by defining CARBON_IRQC_PRIO_EN.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module carbon_irq_ctrl #(
    parameter int N_SRC  = 32,
    parameter int PRIO_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_SRC-1:0]  src_i,
    input  logic              cfg_we,
    input  logic [1:0]        cfg_addr,
    input  logic [31:0]       cfg_wdata,
    output logic              irq_valid,
    output logic [4:0]        irq_vector,
    output logic [PRIO_W-1:0] irq_prio,
    output logic [N_SRC-1:0]  irq_pending,
    input  logic              irq_ack
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESENT = 2'd1,
        ST_GAP     = 2'd2
    } state_t;

    state_t             state_q;
    logic               valid_q;
    logic [4:0]         vector_q;
    logic [PRIO_W-1:0]  prio_q;
    logic [N_SRC-1:0]   pending_q;
    logic [N_SRC-1:0]   src_q;
    logic               armed_q;
    logic [N_SRC-1:0]   pend_q;
    logic [N_SRC-1:0]   pend_d;
    logic [N_SRC-1:0]   enable_q;

    logic [N_SRC-1:0]   w_eligible;
    logic [N_SRC-1:0]   w_set;
    logic [N_SRC-1:0]   w_clr;
    logic               w_ack_present;
    logic [4:0]         w_win_idx;
    logic [PRIO_W-1:0]  w_win_prio;

    assign w_eligible    = pend_q & enable_q;
    assign w_ack_present = (state_q == ST_PRESENT) && irq_ack;

    // armed_q masks the first cycle after reset so a line already high is not an edge
    assign w_set = (src_i & ~src_q & {N_SRC{armed_q}})
                 | ((cfg_we && cfg_addr == 2'd3) ? cfg_wdata[N_SRC-1:0] : '0);

    always_comb begin
        w_clr = '0;
        for (int i = 0; i < N_SRC; i++) begin
            w_clr[i] = w_ack_present && (vector_q == 5'(i));
        end
    end

    // A new set in the ack cycle wins over the clear
    assign pend_d = (pend_q & ~w_clr) | w_set;

`ifdef CARBON_IRQC_PRIO_EN
    logic [31:0]       prio_lo_q;
    logic [31:0]       prio_hi_q;
    logic [PRIO_W-1:0] w_src_prio [N_SRC];

    for (genvar gi = 0; gi < N_SRC; gi++) begin : g_prio
        if (gi < 16) begin : g_lo
            assign w_src_prio[gi] = prio_lo_q[2*gi +: PRIO_W];
        end else begin : g_hi
            assign w_src_prio[gi] = prio_hi_q[2*(gi-16) +: PRIO_W];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio_lo_q <= '0;
            prio_hi_q <= '0;
        end else if (cfg_we) begin
            if (cfg_addr == 2'd1) prio_lo_q <= cfg_wdata;
            if (cfg_addr == 2'd2) prio_hi_q <= cfg_wdata;
        end
    end

    // Strictly-greater compare keeps the lowest index on priority ties
    always_comb begin
        logic found;
        found      = 1'b0;
        w_win_idx  = '0;
        w_win_prio = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (w_eligible[i] && (!found || w_src_prio[i] > w_win_prio)) begin
                found      = 1'b1;
                w_win_idx  = 5'(i);
                w_win_prio = w_src_prio[i];
            end
        end
    end
`else
    always_comb begin
        logic found;
        found      = 1'b0;
        w_win_idx  = '0;
        w_win_prio = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (w_eligible[i] && !found) begin
                found     = 1'b1;
                w_win_idx = 5'(i);
            end
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            src_q     <= '0;
            armed_q   <= 1'b0;
            pend_q    <= '0;
            enable_q  <= '0;
            pending_q <= '0;
        end else begin
            src_q     <= src_i;
            armed_q   <= 1'b1;
            pend_q    <= pend_d;
            pending_q <= w_eligible;
            if (cfg_we && cfg_addr == 2'd0) begin
                enable_q <= cfg_wdata[N_SRC-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            valid_q  <= 1'b0;
            vector_q <= '0;
            prio_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (|w_eligible) begin
                        vector_q <= w_win_idx;
                        prio_q   <= w_win_prio;
                        valid_q  <= 1'b1;
                        state_q  <= ST_PRESENT;
                    end
                end
                ST_PRESENT: begin
                    if (irq_ack) begin
                        valid_q <= 1'b0;
                        state_q <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    valid_q <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign irq_valid   = valid_q;
    assign irq_vector  = vector_q;
    assign irq_prio    = prio_q;
    assign irq_pending = pending_q;

endmodule

`default_nettype wire
